usb_fs_nb_in_buf: RTL and testbench
===================================

// Module: usb_fs_nb_in_buf
// PURPOSE
//  IN-endpoint packet store feeding usb_fs_nb_in_pe. Holds NumBufs flop-based packet
//  buffers plus per-endpoint descriptors (buffer id, size, ready). Serves in_ep_data/
//  has_data/data_done to the PE; retires packets on good end, keeps them on rollback.
//  Software side loads bytes and arms descriptors.
// PARAMETERS
//  NumInEps          12  implemented IN endpoints
//  MaxInPktSizeByte  32  bytes per buffer (power of 2); PktW=$clog2, SizeW=PktW+1
//  NumBufs           8   packet buffers; BufW=$clog2(NumBufs)
// PORTS
//  clk_48mhz_i         in   1         clock
//  rst_ni              in   1         async reset, active low
//  link_reset_i        in   1         USB bus reset
//  buf_we_i            in   1         byte write strobe
//  buf_waddr_i         in   BufW+PktW {buffer id, byte offset}
//  buf_wdata_i         in   8         byte data
//  cfg_we_i            in   1         descriptor write strobe
//  cfg_ep_i            in   4         target endpoint
//  cfg_buf_i           in   BufW      buffer id
//  cfg_size_i          in   SizeW     packet length 0..MaxInPktSizeByte
//  cfg_rdy_i           in   1         arm (1) / disarm (0)
//  cfg_err_o           out  1         pulse: descriptor write rejected
//  in_xact_starting_i  in   1         PE: IN transaction starting
//  in_xact_start_ep_i  in   4         PE: endpoint of starting transaction
//  in_ep_current_i     in   4         PE: current endpoint
//  in_ep_get_addr_i    in   PktW      PE: byte offset requested
//  in_ep_rollback_i    in   1         PE: bad termination
//  in_ep_xact_end_i    in   1         PE: good termination
//  in_ep_has_data_o    out  NumInEps  per-EP packet armed
//  in_ep_data_done_o   out  NumInEps  per-EP offset beyond packet
//  in_ep_data_o        out  8         byte at {buf[current], get_addr}
//  rdy_o               out  NumInEps  descriptor ready bits
//  busy_o              out  NumInEps  transaction in flight per EP
//  pkt_sent_o          out  NumInEps  1-cycle pulse per retired packet
// BEHAVIOUR
//  - Reset (rst_ni low): rdy, busy, pkt_sent, cfg_err, descriptors all 0; buffer RAM not
//    reset; in_ep_data_o = byte 0 of buffer 0 content (X in sim tolerated only pre-write).
//  - Byte write: registered, visible to in_ep_data_o the cycle after buf_we_i.
//  - in_ep_has_data_o[e] = rdy[e], combinational; EPs >= NumInEps ignored everywhere.
//  - in_ep_data_o combinational from RAM[buf[cur]][get_addr]; zero-latency so PE register
//    is the only pipeline stage. cur = in_ep_current_i; out-of-range cur -> data 0.
//  - in_ep_data_done_o[e] = ({1'b0,get_addr} >= size[e]) for e==cur, else 1. Size 0 ->
//    done immediately (ZLP). Size==Max never compares done; PE ends on all-ones addr.
//  - busy[e]: set on in_xact_starting_i & rdy[e] for e=start_ep; cleared on xact_end,
//    rollback, or link_reset_i. Set and clear same cycle: set wins (back-to-back IN).
//  - xact_end with busy[cur]: rdy[cur]<=0, busy<=0, pkt_sent_o[cur] pulse next cycle.
//    xact_end with !busy (ISO no-data): no change, no pulse.
//  - rollback: busy[cur]<=0, rdy/descriptor retained -> packet resent on next IN.
//  - cfg_we_i: if busy[cfg_ep] or cfg_ep>=NumInEps -> ignored, cfg_err_o pulse 1 cycle
//    later; else buf/size/rdy written. cfg_size_i>Max clamps to Max. Same-cycle
//    cfg_we and xact_end on same EP: xact_end applied, write rejected.
//  - link_reset_i: clears rdy and busy for all EPs; descriptors' buf/size retained.
//  - Buffer writes to a buffer armed on a busy EP are not blocked (SW responsibility).
// CONFIGURATION
//  USB_IN_BUF_SENT_CNT_EN defined: adds output sent_cnt_o [NumInEps*8], per-EP 8-bit
//   wrapping counter incremented with each pkt_sent_o pulse (255->0), reset 0, cleared by
//   link_reset_i. Undefined: port and counters absent; all other behaviour identical.
// TESTING
//  - Load buf2 bytes 0..4=A0..A4, arm EP1 size5 -> has_data[1]=1; IN, get 0..4 -> data
//    A0..A4, done[1] at addr5; xact_end -> rdy[1]=0, pkt_sent[1] one pulse.
//  - Armed EP3 size4, rollback after 2 bytes -> rdy[3]=1, busy[3]=0; repeat IN sends full
//    4 bytes again; then xact_end retires it.
//  - cfg_we to EP1 while busy[1]=1 -> cfg_err_o=1 one cycle, descriptor unchanged.
//  - Arm EP0 size0 -> done[0]=1 at addr0; xact_end -> pkt_sent[0]; size 40 -> clamped 32.
//  - Arm EP0,EP2, assert link_reset_i -> rdy=0, busy=0; no pkt_sent pulses.
//  - SENT_CNT_EN: 257 retired packets on EP4 -> sent_cnt[4]=1.

Source files
------------

// File: rtl/usb_fs_nb_in_buf.sv
// IN-endpoint packet store: flop-based packet buffers plus per-endpoint descriptors served to the IN PE.
// Optional per-endpoint sent-packet counters are enabled by defining USB_IN_BUF_SENT_CNT_EN.
module usb_fs_nb_in_buf #(
   parameter int unsigned  NumInEps         = 12,
   parameter int unsigned  MaxInPktSizeByte = 32,
   parameter int unsigned  NumBufs          = 8,
   localparam int unsigned PktW             = $clog2(MaxInPktSizeByte),
   localparam int unsigned SizeW            = PktW + 1,
   localparam int unsigned BufW             = $clog2(NumBufs)
) (
   input  logic                 clk_48mhz_i,
   input  logic                 rst_ni,
   input  logic                 link_reset_i,
   input  logic                 buf_we_i,
   input  logic [BufW+PktW-1:0] buf_waddr_i,
   input  logic [7:0]           buf_wdata_i,
   input  logic                 cfg_we_i,
   input  logic [3:0]           cfg_ep_i,
   input  logic [BufW-1:0]      cfg_buf_i,
   input  logic [SizeW-1:0]     cfg_size_i,
   input  logic                 cfg_rdy_i,
   output logic                 cfg_err_o,
   input  logic                 in_xact_starting_i,
   input  logic [3:0]           in_xact_start_ep_i,
   input  logic [3:0]           in_ep_current_i,
   input  logic [PktW-1:0]      in_ep_get_addr_i,
   input  logic                 in_ep_rollback_i,
   input  logic                 in_ep_xact_end_i,
   output logic [NumInEps-1:0]  in_ep_has_data_o,
   output logic [NumInEps-1:0]  in_ep_data_done_o,
   output logic [7:0]           in_ep_data_o,
   output logic [NumInEps-1:0]  rdy_o,
   output logic [NumInEps-1:0]  busy_o,
   output logic [NumInEps-1:0]  pkt_sent_o
`ifdef USB_IN_BUF_SENT_CNT_EN
   ,
   output logic [NumInEps*8-1:0] sent_cnt_o
`endif
);

   logic [7:0]            mem_q [NumBufs*MaxInPktSizeByte];
   logic [BufW-1:0]       buf_q [NumInEps];
   logic [SizeW-1:0]      size_q [NumInEps];
   logic [NumInEps-1:0]   rdy_q, rdy_d, busy_q, busy_d, pkt_sent_q, pkt_sent_d;
   logic [NumInEps-1:0]   cfg_sel, ep_end;
   logic                  cfg_err_q, cfg_ep_valid, cfg_busy, cfg_conflict, cfg_accept;
   logic [SizeW-1:0]      cfg_size_clamped;
   logic                  cur_valid;
   logic [BufW-1:0]       cur_buf;

   always_ff @(posedge clk_48mhz_i) begin
      if (buf_we_i) mem_q[buf_waddr_i] <= buf_wdata_i;
   end

   always_comb begin
      cur_valid = 1'b0;
      cur_buf   = '0;
      for (int e = 0; e < NumInEps; e++) begin
         if (in_ep_current_i == 4'(e)) begin
            cur_valid = 1'b1;
            cur_buf   = buf_q[e];
         end
      end
   end

   // Zero-latency read: the PE's own output register is the only pipeline stage.
   assign in_ep_data_o = cur_valid ? mem_q[{cur_buf, in_ep_get_addr_i}] : 8'h00;

   assign cfg_ep_valid     = cfg_ep_i < 4'(NumInEps);
   assign cfg_busy         = |(cfg_sel & busy_q);
   assign cfg_conflict     = in_ep_xact_end_i && (cfg_ep_i == in_ep_current_i);
   assign cfg_accept       = cfg_we_i && cfg_ep_valid && !cfg_busy && !cfg_conflict;
   assign cfg_size_clamped = (cfg_size_i > SizeW'(MaxInPktSizeByte)) ?
                             SizeW'(MaxInPktSizeByte) : cfg_size_i;

   for (genvar gi = 0; gi < NumInEps; gi++) begin : g_ep
      logic sel_cur, busy_set, busy_clr;
      assign sel_cur     = (in_ep_current_i == 4'(gi));
      assign cfg_sel[gi] = (cfg_ep_i == 4'(gi));
      assign busy_set    = in_xact_starting_i && (in_xact_start_ep_i == 4'(gi)) && rdy_q[gi];
      assign busy_clr    = sel_cur && (in_ep_xact_end_i || in_ep_rollback_i);
      assign ep_end[gi]  = in_ep_xact_end_i && sel_cur && busy_q[gi];

      // A new start beats a same-cycle end/rollback so back-to-back INs stay busy.
      assign busy_d[gi] = link_reset_i ? 1'b0 :
                          busy_set     ? 1'b1 :
                          busy_clr     ? 1'b0 : busy_q[gi];
      assign rdy_d[gi]  = link_reset_i                ? 1'b0 :
                          ep_end[gi]                  ? 1'b0 :
                          (cfg_accept && cfg_sel[gi]) ? cfg_rdy_i : rdy_q[gi];
      assign pkt_sent_d[gi] = ep_end[gi] && !link_reset_i;

      assign in_ep_data_done_o[gi] = sel_cur ? ({1'b0, in_ep_get_addr_i} >= size_q[gi]) : 1'b1;
   end

   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_q      <= '0;
         busy_q     <= '0;
         pkt_sent_q <= '0;
         cfg_err_q  <= 1'b0;
         for (int e = 0; e < NumInEps; e++) begin
            buf_q[e]  <= '0;
            size_q[e] <= '0;
         end
      end else begin
         rdy_q      <= rdy_d;
         busy_q     <= busy_d;
         pkt_sent_q <= pkt_sent_d;
         cfg_err_q  <= cfg_we_i && !cfg_accept;
         for (int e = 0; e < NumInEps; e++) begin
            if (cfg_accept && cfg_sel[e]) begin
               buf_q[e]  <= cfg_buf_i;
               size_q[e] <= cfg_size_clamped;
            end
         end
      end
   end

   assign in_ep_has_data_o = rdy_q;
   assign rdy_o            = rdy_q;
   assign busy_o           = busy_q;
   assign pkt_sent_o       = pkt_sent_q;
   assign cfg_err_o        = cfg_err_q;

`ifdef USB_IN_BUF_SENT_CNT_EN
   logic [7:0] sent_cnt_q [NumInEps];

   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < NumInEps; e++) sent_cnt_q[e] <= '0;
      end else begin
         for (int e = 0; e < NumInEps; e++) begin
            if (link_reset_i)       sent_cnt_q[e] <= '0;
            else if (pkt_sent_q[e]) sent_cnt_q[e] <= sent_cnt_q[e] + 8'd1;
         end
      end
   end

   for (genvar gi = 0; gi < NumInEps; gi++) begin : g_cnt
      assign sent_cnt_o[gi*8 +: 8] = sent_cnt_q[gi];
   end
`endif

endmodule

// File: tb/tb_usb_fs_nb_in_buf.sv
// Self-checking bench for usb_fs_nb_in_buf; read expectations go through a scoreboard queue.
module tb_usb_fs_nb_in_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        link_reset = 1'b0;
   logic        buf_we = 1'b0;
   logic [7:0]  waddr = '0;
   logic [7:0]  wdata = '0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_ep = '0;
   logic [2:0]  cfg_buf = '0;
   logic [5:0]  cfg_size = '0;
   logic        cfg_rdy = 1'b0;
   logic        cfg_err;
   logic        starting = 1'b0;
   logic [3:0]  start_ep = '0;
   logic [3:0]  cur = '0;
   logic [4:0]  get_addr = '0;
   logic        rollback = 1'b0;
   logic        xend = 1'b0;
   logic [11:0] has_data, done, rdy, busy, pkt_sent;
   logic [7:0]  data;
`ifdef USB_IN_BUF_SENT_CNT_EN
   logic [95:0] sent_cnt;
`endif

   logic [7:0]  mem_m [256];
   logic [2:0]  m_buf [12];
   logic [5:0]  m_size [12];
   logic [19:0] exp_q [$];
   logic [19:0] e;
   int          n_chk = 0;
   int          n_pass = 0;

   always #10 clk = ~clk;

   usb_fs_nb_in_buf dut (
      .clk_48mhz_i       (clk),
      .rst_ni            (rst_n),
      .link_reset_i      (link_reset),
      .buf_we_i          (buf_we),
      .buf_waddr_i       (waddr),
      .buf_wdata_i       (wdata),
      .cfg_we_i          (cfg_we),
      .cfg_ep_i          (cfg_ep),
      .cfg_buf_i         (cfg_buf),
      .cfg_size_i        (cfg_size),
      .cfg_rdy_i         (cfg_rdy),
      .cfg_err_o         (cfg_err),
      .in_xact_starting_i(starting),
      .in_xact_start_ep_i(start_ep),
      .in_ep_current_i   (cur),
      .in_ep_get_addr_i  (get_addr),
      .in_ep_rollback_i  (rollback),
      .in_ep_xact_end_i  (xend),
      .in_ep_has_data_o  (has_data),
      .in_ep_data_done_o (done),
      .in_ep_data_o      (data),
      .rdy_o             (rdy),
      .busy_o            (busy),
      .pkt_sent_o        (pkt_sent)
`ifdef USB_IN_BUF_SENT_CNT_EN
      ,
      .sent_cnt_o        (sent_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [2:0] b, input logic [4:0] o, input logic [7:0] d);
      buf_we = 1'b1; waddr = {b, o}; wdata = d;
      mem_m[{b, o}] = d;
      tick();
      buf_we = 1'b0;
   endtask

   // Drives one descriptor write; the model is updated only when the write should be accepted.
   task automatic arm(input logic [3:0] ep, input logic [2:0] b, input logic [5:0] sz,
                      input logic r, input bit ok);
      cfg_we = 1'b1; cfg_ep = ep; cfg_buf = b; cfg_size = sz; cfg_rdy = r;
      if (ok && ep < 12) begin
         m_buf[ep]  = b;
         m_size[ep] = (sz > 6'd32) ? 6'd32 : sz;
      end
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_in(input logic [3:0] ep);
      starting = 1'b1; start_ep = ep;
      tick();
      starting = 1'b0;
   endtask

   task automatic xact_end(input logic [3:0] ep);
      cur = ep; xend = 1'b1;
      tick();
      xend = 1'b0;
   endtask

   task automatic issue_get(input logic [3:0] ep, input logic [4:0] a);
      logic [11:0] dv;
      cur = ep; get_addr = a;
      dv = '1;
      dv[ep] = ({1'b0, a} >= m_size[ep]);
      exp_q.push_back({dv, mem_m[{m_buf[ep], a}]});
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 12; i++) begin m_buf[i] = '0; m_size[i] = '0; end
      rst_n = 1'b0;
      repeat (2) tick();
      n_chk++;
      if ({rdy, busy, pkt_sent, has_data, cfg_err} !== 49'd0) begin
         $display("FAIL reset_state: got rdy=%h busy=%h sent=%h has=%h err=%b exp all 0",
                  rdy, busy, pkt_sent, has_data, cfg_err);
      end else n_pass++;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) write_byte(3'(i >> 5), 5'(i), 8'($urandom));
      issue_get(4'd0, 5'd0);
      e = exp_q.pop_front(); n_chk++;
      if ({done, data} !== e) $display("FAIL reset_read: got %h exp %h", {done, data}, e);
      else n_pass++;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 5; i++) write_byte(3'd2, 5'(i), 8'hA0 + 8'(i));
      arm(4'd1, 3'd2, 6'd5, 1'b1, 1'b1);
      n_chk++;
      if (has_data !== 12'h002 || rdy !== 12'h002)
         $display("FAIL basic_has_data: got has=%h rdy=%h exp 002", has_data, rdy);
      else n_pass++;
      start_in(4'd1);
      n_chk++;
      if (busy !== 12'h002) $display("FAIL basic_busy: got %h exp 002", busy);
      else n_pass++;
      for (int a = 0; a < 6; a++) begin
         issue_get(4'd1, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e)
            $display("FAIL basic_read addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
      xact_end(4'd1);
      n_chk++;
      if (rdy !== 12'h000 || busy !== 12'h000 || pkt_sent !== 12'h002)
         $display("FAIL basic_retire: got rdy=%h busy=%h sent=%h exp 000/000/002", rdy, busy, pkt_sent);
      else n_pass++;
      tick();
      n_chk++;
      if (pkt_sent !== 12'h000) $display("FAIL basic_pulse_width: got %h exp 000", pkt_sent);
      else n_pass++;
   endtask

   task automatic test_rollback();
      for (int i = 0; i < 4; i++) write_byte(3'd5, 5'(i), 8'hB0 + 8'(i));
      arm(4'd3, 3'd5, 6'd4, 1'b1, 1'b1);
      start_in(4'd3);
      for (int a = 0; a < 2; a++) begin
         issue_get(4'd3, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e) $display("FAIL rb_read1 addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
      cur = 4'd3; rollback = 1'b1;
      tick();
      rollback = 1'b0;
      n_chk++;
      if (rdy[3] !== 1'b1 || busy[3] !== 1'b0 || pkt_sent !== 12'h000)
         $display("FAIL rb_state: got rdy3=%b busy3=%b sent=%h exp 1/0/000", rdy[3], busy[3], pkt_sent);
      else n_pass++;
      start_in(4'd3);
      for (int a = 0; a < 5; a++) begin
         issue_get(4'd3, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e) $display("FAIL rb_read2 addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
      xact_end(4'd3);
      n_chk++;
      if (rdy[3] !== 1'b0 || pkt_sent !== 12'h008)
         $display("FAIL rb_retire: got rdy3=%b sent=%h exp 0/008", rdy[3], pkt_sent);
      else n_pass++;
   endtask

   task automatic test_cfg_busy();
      arm(4'd1, 3'd2, 6'd5, 1'b1, 1'b1);
      start_in(4'd1);
      arm(4'd1, 3'd7, 6'd3, 1'b0, 1'b0);
      n_chk++;
      if (cfg_err !== 1'b1) $display("FAIL cfg_busy_err: got %b exp 1", cfg_err);
      else n_pass++;
      tick();
      n_chk++;
      if (cfg_err !== 1'b0 || rdy[1] !== 1'b1)
         $display("FAIL cfg_busy_after: got err=%b rdy1=%b exp 0/1", cfg_err, rdy[1]);
      else n_pass++;
      for (int a = 3; a < 6; a++) begin
         issue_get(4'd1, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e) $display("FAIL cfg_busy_desc addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
      arm(4'd13, 3'd1, 6'd2, 1'b1, 1'b0);
      n_chk++;
      if (cfg_err !== 1'b1 || rdy !== 12'h002)
         $display("FAIL cfg_bad_ep: got err=%b rdy=%h exp 1/002", cfg_err, rdy);
      else n_pass++;
      xact_end(4'd1);
      n_chk++;
      if (pkt_sent !== 12'h002) $display("FAIL cfg_busy_retire: got %h exp 002", pkt_sent);
      else n_pass++;
   endtask

   task automatic test_zlp_clamp();
      arm(4'd0, 3'd0, 6'd0, 1'b1, 1'b1);
      issue_get(4'd0, 5'd0);
      e = exp_q.pop_front(); n_chk++;
      if ({done, data} !== e) $display("FAIL zlp_done: got %h exp %h", {done, data}, e);
      else n_pass++;
      start_in(4'd0);
      xact_end(4'd0);
      n_chk++;
      if (pkt_sent !== 12'h001 || rdy[0] !== 1'b0)
         $display("FAIL zlp_retire: got sent=%h rdy0=%b exp 001/0", pkt_sent, rdy[0]);
      else n_pass++;
      arm(4'd0, 3'd1, 6'd40, 1'b1, 1'b1);
      for (int a = 30; a < 32; a++) begin
         issue_get(4'd0, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e) $display("FAIL clamp_read addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      arm(4'd2, 3'd3, 6'd6, 1'b1, 1'b1);
      start_in(4'd2);
      cur = 4'd2; rollback = 1'b1; starting = 1'b1; start_ep = 4'd2;
      tick();
      rollback = 1'b0; starting = 1'b0;
      n_chk++;
      if (busy[2] !== 1'b1) $display("FAIL b2b_set_wins: got busy2=%b exp 1", busy[2]);
      else n_pass++;
      xact_end(4'd2);
      n_chk++;
      if (pkt_sent !== 12'h004 || busy[2] !== 1'b0)
         $display("FAIL b2b_retire: got sent=%h busy2=%b exp 004/0", pkt_sent, busy[2]);
      else n_pass++;
      arm(4'd6, 3'd4, 6'd3, 1'b1, 1'b1);
      xact_end(4'd6);
      n_chk++;
      if (pkt_sent !== 12'h000 || rdy[6] !== 1'b1)
         $display("FAIL iso_no_data: got sent=%h rdy6=%b exp 000/1", pkt_sent, rdy[6]);
      else n_pass++;
   endtask

   task automatic test_link_reset();
      arm(4'd2, 3'd3, 6'd6, 1'b1, 1'b1);
      start_in(4'd2);
      link_reset = 1'b1;
      tick();
      link_reset = 1'b0;
      n_chk++;
      if (rdy !== 12'h000 || busy !== 12'h000 || pkt_sent !== 12'h000)
         $display("FAIL link_reset: got rdy=%h busy=%h sent=%h exp 000", rdy, busy, pkt_sent);
      else n_pass++;
      tick();
      n_chk++;
      if (pkt_sent !== 12'h000) $display("FAIL link_reset_pulse: got %h exp 000", pkt_sent);
      else n_pass++;
      for (int a = 5; a < 7; a++) begin
         issue_get(4'd2, 5'(a));
         e = exp_q.pop_front(); n_chk++;
         if ({done, data} !== e) $display("FAIL link_reset_desc addr=%0d: got %h exp %h", a, {done, data}, e);
         else n_pass++;
      end
   endtask

`ifdef USB_IN_BUF_SENT_CNT_EN
   task automatic test_sent_cnt();
      n_chk++;
      if (sent_cnt[32 +: 8] !== 8'd0) $display("FAIL sent_cnt_start: got %0d exp 0", sent_cnt[32 +: 8]);
      else n_pass++;
      for (int i = 0; i < 257; i++) begin
         arm(4'd4, 3'd6, 6'd1, 1'b1, 1'b1);
         start_in(4'd4);
         xact_end(4'd4);
      end
      tick();
      n_chk++;
      if (sent_cnt[32 +: 8] !== 8'd1) $display("FAIL sent_cnt_wrap: got %0d exp 1", sent_cnt[32 +: 8]);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_rollback();
      test_cfg_busy();
      test_zlp_clamp();
      test_back_to_back();
      test_link_reset();
`ifdef USB_IN_BUF_SENT_CNT_EN
      test_sent_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
